// File: rtl/eth_udp_pkt_tx_framer.sv
// eth_udp_pkt_tx_framer: builds Ethernet/IPv4/UDP frames for one egress flow
// and streams header, payload and padding into the Gbit MAC Tx FIFO port.
module eth_udp_pkt_tx_framer #(
  parameter logic [47:0] P_SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [47:0] P_DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [31:0] P_SRC_IP      = 32'hC0A8_0102,
  parameter logic [31:0] P_DST_IP      = 32'hC0A8_0101,
  parameter logic [15:0] P_SRC_PORT    = 16'd50000,
  parameter logic [15:0] P_DST_PORT    = 16'd50000,
  parameter logic [7:0]  P_TTL         = 8'd64,
  parameter int unsigned P_MAX_PAYLOAD = 1472
) (
  input  logic        i_txmac_clk,
  input  logic        i_txmac_arst_n,
  input  logic        i_pkt_start,
  input  logic [15:0] i_pkt_len,
  output logic        o_busy,
  input  logic [7:0]  i_payload_byte,
  input  logic        i_payload_byte_vld,
  input  logic        i_payload_last_byte,
  output logic        o_payload_byte_rd,
  output logic [7:0]  o_tx_fifodata,
  output logic        o_tx_fifoavail,
  output logic        o_tx_fifoeof,
  output logic        o_tx_fifoempty,
  input  logic        i_tx_macread,
  input  logic        i_tx_done,
  input  logic        i_tx_discfrm,
  output logic        o_len_err,
  output logic        o_len_mismatch_err
);

  typedef enum logic [2:0] {
    IDLE, CSUM, HDR, PAYLOAD, PAD, WAIT_DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0] len_q;
  logic [15:0] id_q;
  logic [15:0] csum_q;
  logic [19:0] sum_q;
  logic [10:0] pos_q;
  logic        zfill_q;
  logic        drain_q;
  logic        done_q;
  logic        len_err_q;
  logic        mism_q;

  logic        avail;
  logic [7:0]  data;
  logic        eof;
  logic        rd;
  logic        len_ok;
  logic [15:0] last_pos;
  logic        at_n;
  logic        big;
  logic        xfer;
  logic        early;
  logic        late;
  logic        drain_pop;
  logic        drain_clr;
  logic        done_any;
  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [15:0] word;
  logic [335:0] hdr;
  logic [7:0]  hdr_byte;

  assign len_ok = (i_pkt_len != 16'd0) &&
                  (32'(i_pkt_len) <= P_MAX_PAYLOAD);

  assign tot_len  = len_q + 16'd28;
  assign udp_len  = len_q + 16'd8;
  // pos_q is the frame byte index; payload byte N sits at index N+41
  assign last_pos = len_q + 16'd41;
  assign at_n     = ({5'd0, pos_q} == last_pos);
  assign big      = (len_q >= 16'd18);

  assign xfer      = i_tx_macread & avail;
  assign early     = (state_q == PAYLOAD) & xfer & ~zfill_q &
                     i_payload_last_byte & ~at_n;
  assign late      = (state_q == PAYLOAD) & xfer & ~zfill_q &
                     ~i_payload_last_byte & at_n;
  assign drain_pop = drain_q & i_payload_byte_vld;
  assign drain_clr = ~drain_q | (drain_pop & i_payload_last_byte);
  assign done_any  = i_tx_done | i_tx_discfrm;

  assign hdr = {P_DST_MAC, P_SRC_MAC, 16'h0800,
                8'h45, 8'h00, tot_len, id_q, 16'h4000,
                P_TTL, 8'h11, csum_q, P_SRC_IP, P_DST_IP,
                P_SRC_PORT, P_DST_PORT, udp_len, 16'h0000};

  assign hdr_byte =
    hdr[10'd335 - {1'b0, pos_q[5:0], 3'b000} -: 8];

  always_comb begin
    word = 16'h0000;
    case (pos_q[3:0])
      4'd0:    word = 16'h4500;
      4'd1:    word = tot_len;
      4'd2:    word = id_q;
      4'd3:    word = 16'h4000;
      4'd4:    word = {P_TTL, 8'h11};
      4'd6:    word = P_SRC_IP[31:16];
      4'd7:    word = P_SRC_IP[15:0];
      4'd8:    word = P_DST_IP[31:16];
      4'd9:    word = P_DST_IP[15:0];
      default: word = 16'h0000;
    endcase
  end

  always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
    if (!i_txmac_arst_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    avail   = 1'b0;
    data    = 8'h00;
    eof     = 1'b0;
    rd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_pkt_start && len_ok) state_d = CSUM;
      end
      CSUM: begin
        if (pos_q == 11'd11) state_d = HDR;
      end
      HDR: begin
        avail = 1'b1;
        data  = hdr_byte;
        if (i_tx_macread && pos_q == 11'd41) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        avail = zfill_q | i_payload_byte_vld;
        data  = zfill_q ? 8'h00 : i_payload_byte;
        rd    = ~zfill_q & i_tx_macread & i_payload_byte_vld;
        eof   = at_n & big;
        if (i_tx_macread && avail && at_n)
          state_d = big ? WAIT_DONE : PAD;
      end
      PAD: begin
        avail = 1'b1;
        rd    = drain_pop;
        eof   = (pos_q == 11'd59);
        if (i_tx_macread && eof) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        rd = drain_pop;
        if ((done_any || done_q) && drain_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
    if (!i_txmac_arst_n) begin
      len_q     <= 16'd0;
      id_q      <= 16'd0;
      csum_q    <= 16'd0;
      sum_q     <= 20'd0;
      pos_q     <= 11'd0;
      zfill_q   <= 1'b0;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      len_err_q <= (state_q == IDLE) && i_pkt_start && !len_ok;
      mism_q    <= early | late;
      if (drain_pop && i_payload_last_byte) drain_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_pkt_start && len_ok) begin
            len_q   <= i_pkt_len;
            pos_q   <= 11'd0;
            sum_q   <= 20'd0;
            zfill_q <= 1'b0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        CSUM: begin
          pos_q <= pos_q + 11'd1;
          if (pos_q < 11'd10) begin
            sum_q <= sum_q + {4'd0, word};
          end else if (pos_q == 11'd10) begin
            sum_q <= {3'd0, {1'b0, sum_q[15:0]} +
                            {13'd0, sum_q[19:16]}};
          end else begin
            csum_q <= ~(sum_q[15:0] + {12'd0, sum_q[19:16]});
            pos_q  <= 11'd0;
          end
        end
        HDR, PAYLOAD, PAD: begin
          if (xfer)  pos_q   <= pos_q + 11'd1;
          if (early) zfill_q <= 1'b1;
          if (late)  drain_q <= 1'b1;
        end
        WAIT_DONE: begin
          // a discarded frame reuses its ID
          if (i_tx_done && !done_q) id_q <= id_q + 16'd1;
          if (done_any) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy             = (state_q != IDLE);
  assign o_payload_byte_rd  = rd;
  assign o_tx_fifodata      = data;
  assign o_tx_fifoavail     = avail;
  assign o_tx_fifoeof       = eof & avail;
  assign o_tx_fifoempty     = ~avail;
  assign o_len_err          = len_err_q;
  assign o_len_mismatch_err = mism_q;

endmodule

// File: tb/tb_eth_udp_pkt_tx_framer.sv
// Scoreboard bench for eth_udp_pkt_tx_framer: expected frame bytes are
// queued at stimulus time and popped by a monitor on each MAC read.
module tb_eth_udp_pkt_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_start = 1'b0;
  logic [15:0] pkt_len = 16'd0;
  logic        busy;
  logic [7:0]  pb = 8'h00;
  logic        pvld = 1'b0;
  logic        plast = 1'b0;
  logic        prd;
  logic [7:0]  txd;
  logic        tavail, teof, tempty;
  logic        macread = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_disc = 1'b0;
  logic        len_err, mism;

  always #5 clk = ~clk;

  eth_udp_pkt_tx_framer dut (
    .i_txmac_clk        (clk),
    .i_txmac_arst_n     (rst_n),
    .i_pkt_start        (pkt_start),
    .i_pkt_len          (pkt_len),
    .o_busy             (busy),
    .i_payload_byte     (pb),
    .i_payload_byte_vld (pvld),
    .i_payload_last_byte(plast),
    .o_payload_byte_rd  (prd),
    .o_tx_fifodata      (txd),
    .o_tx_fifoavail     (tavail),
    .o_tx_fifoeof       (teof),
    .o_tx_fifoempty     (tempty),
    .i_tx_macread       (macread),
    .i_tx_done          (tx_done),
    .i_tx_discfrm       (tx_disc),
    .o_len_err          (len_err),
    .o_len_mismatch_err (mism)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } ent_t;

  ent_t        up_q[$];
  ent_t        exp_q[$];
  ent_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          len_err_cnt = 0;
  int          mism_cnt = 0;
  int          rx_cnt = 0;
  logic [7:0]  rx [2048];
  logic [7:0]  eh [42];
  bit          gap_mode = 1'b0;
  bit          mon_en = 1'b1;
  logic        rd_s = 1'b0;
  logic        vgate = 1'b1;
  logic [15:0] exp_id = 16'd0;
  int          exp_total = 0;
  int          exp_idx = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    rd_s = prd;
    if (rst_n) begin
      if (len_err) len_err_cnt++;
      if (mism) mism_cnt++;
      if (mon_en) begin
        check("empty_vs_avail", {31'd0, tempty}, {31'd0, ~tavail});
        if (tavail && macread) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: actual=%0h required=none",
                     txd);
          end else begin
            mon_e = exp_q.pop_front();
            check("byte_data", {24'd0, txd}, {24'd0, mon_e.d});
            check("byte_eof", {31'd0, teof}, {31'd0, mon_e.last});
            if (rx_cnt < 2048) rx[rx_cnt] = txd;
            rx_cnt++;
          end
        end
      end
    end
  end

  // upstream FWFT FIFO and MAC read pacing
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_s && up_q.size() > 0) void'(up_q.pop_front());
      macread = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      vgate   = gap_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
      pvld    = vgate && (up_q.size() > 0);
      pb      = (up_q.size() > 0) ? up_q[0].d : 8'h00;
      plast   = (up_q.size() > 0) ? up_q[0].last : 1'b0;
    end
  end

  function automatic void build_hdr(input int n, input logic [15:0] id);
    logic [15:0] tl;
    logic [15:0] ul;
    logic [31:0] s;
    tl = 16'(n + 28);
    ul = 16'(n + 8);
    for (int i = 0; i < 6; i++) eh[i] = 8'hFF;
    eh[6] = 8'h02; eh[7] = 8'h00; eh[8] = 8'h00;
    eh[9] = 8'h00; eh[10] = 8'h00; eh[11] = 8'h01;
    eh[12] = 8'h08; eh[13] = 8'h00;
    eh[14] = 8'h45; eh[15] = 8'h00;
    eh[16] = tl[15:8]; eh[17] = tl[7:0];
    eh[18] = id[15:8]; eh[19] = id[7:0];
    eh[20] = 8'h40; eh[21] = 8'h00;
    eh[22] = 8'd64; eh[23] = 8'h11;
    eh[24] = 8'h00; eh[25] = 8'h00;
    eh[26] = 8'hC0; eh[27] = 8'hA8; eh[28] = 8'h01; eh[29] = 8'h02;
    eh[30] = 8'hC0; eh[31] = 8'hA8; eh[32] = 8'h01; eh[33] = 8'h01;
    eh[34] = 8'hC3; eh[35] = 8'h50; eh[36] = 8'hC3; eh[37] = 8'h50;
    eh[38] = ul[15:8]; eh[39] = ul[7:0];
    eh[40] = 8'h00; eh[41] = 8'h00;
    s = 32'd0;
    for (int i = 14; i < 34; i += 2) s += {16'd0, eh[i], eh[i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    eh[24] = ~s[15:8];
    eh[25] = ~s[7:0];
  endfunction

  function automatic logic [15:0] rx_hdr_sum();
    logic [31:0] s;
    s = 32'd0;
    for (int i = 14; i < 34; i += 2) s += {16'd0, rx[i], rx[i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic push_exp(input logic [7:0] d);
    ent_t t;
    t.d    = d;
    t.last = (exp_idx == exp_total - 1);
    exp_q.push_back(t);
    exp_idx++;
  endtask

  task automatic pulse_start(input logic [15:0] len);
    @(posedge clk);
    #1;
    pkt_start = 1'b1;
    pkt_len   = len;
    @(posedge clk);
    #1;
    pkt_start = 1'b0;
  endtask

  task automatic run_frame(input int n, input int last_k,
                           input logic [7:0] base, input bit gaps,
                           input bit disc, input bit bstart,
                           input int exp_mism, input string tag);
    int   lat;
    int   m0;
    int   l0;
    int   guard;
    ent_t u;
    build_hdr(n, exp_id);
    exp_total = (n + 42 < 60) ? 60 : n + 42;
    exp_idx   = 0;
    for (int i = 0; i < 42; i++) push_exp(eh[i]);
    for (int k = 1; k <= n; k++)
      push_exp((k <= last_k) ? 8'(base + k - 1) : 8'h00);
    while (exp_idx < exp_total) push_exp(8'h00);
    for (int k = 1; k <= last_k; k++) begin
      u.d    = 8'(base + k - 1);
      u.last = (k == last_k);
      up_q.push_back(u);
    end
    gap_mode = gaps;
    rx_cnt   = 0;
    m0       = mism_cnt;
    l0       = len_err_cnt;
    pulse_start(16'(n));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tavail && lat < 100);
    check({tag, "_latency"}, lat, 13);
    if (bstart) pulse_start(16'd0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    if (disc) tx_disc = 1'b1;
    else      tx_done = 1'b1;
    @(posedge clk);
    #1;
    tx_disc = 1'b0;
    tx_done = 1'b0;
    if (!disc) exp_id++;
    guard = 0;
    while (busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
    check({tag, "_mismatch"}, mism_cnt - m0, exp_mism);
    check({tag, "_len_err"}, len_err_cnt - l0, 0);
    check({tag, "_drained"}, up_q.size(), 0);
    check({tag, "_count"}, rx_cnt, exp_total);
    gap_mode = 1'b0;
  endtask

  task automatic len_err_test(input logic [15:0] len, input string tag);
    int l0;
    int bad;
    l0  = len_err_cnt;
    bad = 0;
    pulse_start(len);
    repeat (20) begin
      @(negedge clk);
      if (busy || tavail) bad++;
    end
    check({tag, "_pulses"}, len_err_cnt - l0, 1);
    check({tag, "_busy_avail"}, bad, 0);
  endtask

  initial begin
    int   zeros;
    int   guard;
    ent_t u;
    #3;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_avail", {31'd0, tavail}, 0);
    check("rst_empty", {31'd0, tempty}, 1);
    check("rst_eof", {31'd0, teof}, 0);
    check("rst_data", {24'd0, txd}, 0);
    check("rst_rd", {31'd0, prd}, 0);
    check("rst_len_err", {31'd0, len_err}, 0);
    check("rst_mism", {31'd0, mism}, 0);
    #20;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(18, 18, 8'h00, 1'b0, 1'b0, 1'b0, 0, "n18");
    check("n18_total_len", {16'd0, rx[16], rx[17]}, 32'h002E);
    check("n18_udp_len", {16'd0, rx[38], rx[39]}, 32'h001A);
    check("n18_hdr_sum", {16'd0, rx_hdr_sum()}, 32'hFFFF);
    check("n18_csum", {16'd0, rx[24], rx[25]}, 32'hB76B);
    check("n18_id", {16'd0, rx[18], rx[19]}, 32'h0000);

    run_frame(1, 1, 8'hA5, 1'b0, 1'b0, 1'b1, 0, "n1");
    check("n1_id", {16'd0, rx[18], rx[19]}, 32'h0001);
    check("n1_byte43", {24'd0, rx[42]}, 32'hA5);
    zeros = 0;
    for (int i = 43; i < 60; i++) if (rx[i] == 8'h00) zeros++;
    check("n1_pad_zeros", zeros, 17);

    len_err_test(16'd0, "len0");
    len_err_test(16'd1473, "len1473");

    run_frame(10, 6, 8'h30, 1'b0, 1'b1, 1'b0, 1, "early");
    check("early_byte48", {24'd0, rx[47]}, 32'h35);
    zeros = 0;
    for (int i = 48; i < 52; i++) if (rx[i] == 8'h00) zeros++;
    check("early_zero_fill", zeros, 4);
    check("early_id", {16'd0, rx[18], rx[19]}, 32'h0002);

    run_frame(4, 8, 8'h60, 1'b0, 1'b0, 1'b0, 1, "late");
    check("disc_no_inc_id", {16'd0, rx[18], rx[19]}, 32'h0002);

    run_frame(1472, 1472, 8'h00, 1'b1, 1'b0, 1'b0, 0, "n1472");
    check("n1472_id", {16'd0, rx[18], rx[19]}, 32'h0003);

    mon_en = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      u.d    = 8'(k);
      u.last = (k == 18);
      up_q.push_back(u);
    end
    pulse_start(16'd18);
    guard = 0;
    while (!tavail && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_hdr", {31'd0, tavail}, 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_avail", {31'd0, tavail}, 0);
    up_q.delete();
    exp_id = 16'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    run_frame(18, 18, 8'h00, 1'b0, 1'b0, 1'b0, 0, "post_rst");
    check("post_rst_id", {16'd0, rx[18], rx[19]}, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
